// File: rtl/spike_injector_pkg.sv
// Shared definitions for the spike injector.
//   state_t         : FSM state encoding (IDLE, SPIKE, HOLD)
//   TAP_MASK        : Fibonacci LFSR feedback taps x^16+x^14+x^13+x^11+1
//                     (register bits 15, 13, 12, 10)
//   POS_FS / NEG_FS : full-scale values substituted for spike samples
//   lfsr_next()     : one shift step of the 16-bit LFSR
package spike_injector_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPIKE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [15:0]        TAP_MASK = 16'hB400;
    localparam logic signed [15:0] POS_FS   = 16'sh7FFF;
    localparam logic signed [15:0] NEG_FS   = 16'sh8000;

    // Shift left; the new bit 0 is the parity of the tapped bits.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & TAP_MASK)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit free-running Fibonacci LFSR.
// Ports:
//   Clk   : clock, rising edge
//   Reset : asynchronous active-high reset, loads seed
//   seed  : reset value (must be non-zero; caller substitutes)
//   q     : current LFSR state
module lfsr16
    import spike_injector_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q <= seed;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/spike_injector.sv
// Injects full-scale spikes into a sample stream at pseudo-random times.
// A spike starts in IDLE when lfsr[7:0] < Threshold, lasts SpikeWidth+1
// samples of +/- full scale (sign from lfsr[15]), and is followed by HOLDOFF
// cycles of forced pass-through. The stream has no handshake: one sample in
// and one sample out per clock, Output registered once.
// Parameters:
//   SEED    : LFSR reset value (0 is replaced by 16'h0001)
//   HOLDOFF : pass-through cycles after every spike, 1..15
// Ports:
//   Clk        : clock, rising edge
//   Reset      : asynchronous active-high reset
//   Input      : clean signed sample stream
//   Enable     : 1 = injection allowed, 0 = pass-through (aborts spike/hold)
//   Threshold  : spike start probability control
//   SpikeWidth : spike length minus one
//   Output     : registered corrupted stream
//   SpikeFlag  : high while Output carries a spike sample
//   dbg_state  : current FSM state, for observation only
module spike_injector
    import spike_injector_pkg::*;
#(
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          HOLDOFF = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic signed [15:0] Input,
    input  logic               Enable,
    input  logic [7:0]         Threshold,
    input  logic [1:0]         SpikeWidth,
    output logic signed [15:0] Output,
    output logic               SpikeFlag,
    output state_t             dbg_state
);

    // An all-zero seed would lock the LFSR up.
    localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [3:0]  HOLD_LAST = 4'(HOLDOFF - 1);

    logic [15:0] lfsr_q;

    lfsr16 u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .seed  (SEED_EFF),
        .q     (lfsr_q)
    );

    state_t             state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;      // spike samples shown / hold cycles spent
    logic [2:0]         width, width_nxt;  // latched spike length, 1..4
    logic               pol, pol_nxt;      // latched polarity, 1 = negative
    logic signed [15:0] out_nxt;
    logic               flag_nxt;
    logic               start;

    assign start     = Enable && (lfsr_q[7:0] < Threshold);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        width_nxt = width;
        pol_nxt   = pol;
        out_nxt   = Input;
        flag_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    // The first spike sample leaves on the same edge that
                    // enters SPIKE, so it counts as sample 1.
                    state_nxt = SPIKE;
                    width_nxt = {1'b0, SpikeWidth} + 3'd1;
                    pol_nxt   = lfsr_q[15];
                    cnt_nxt   = 4'd1;
                    flag_nxt  = 1'b1;
                    out_nxt   = lfsr_q[15] ? NEG_FS : POS_FS;
                end
            end
            SPIKE: begin
                if (!Enable) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == {1'b0, width}) begin
                    state_nxt = HOLD;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt  = cnt + 4'd1;
                    flag_nxt = 1'b1;
                    out_nxt  = pol ? NEG_FS : POS_FS;
                end
            end
            HOLD: begin
                if (!Enable || cnt == HOLD_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            width     <= 3'd0;
            pol       <= 1'b0;
            Output    <= 16'sd0;
            SpikeFlag <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            width     <= width_nxt;
            pol       <= pol_nxt;
            Output    <= out_nxt;
            SpikeFlag <= flag_nxt;
        end
    end

endmodule

// File: tb/tb_spike_injector.sv
// Bench for spike_injector: the driver pushes the expected {state, flag,
// Output} for every clock into exp_q; the monitor pops and compares one entry
// after every rising edge. Expected values come from hand-computed vectors
// and from an independent behavioural model of the injector.
module tb_spike_injector;
    import spike_injector_pkg::*;

    localparam int          HOLDOFF = 4;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic               clk;
    logic               rst;
    logic signed [15:0] din;
    logic               en;
    logic [7:0]         thr;
    logic [1:0]         sw;
    logic signed [15:0] dout;
    logic               flag;
    state_t             st;

    spike_injector #(.SEED(SEED), .HOLDOFF(HOLDOFF)) dut (
        .Clk        (clk),
        .Reset      (rst),
        .Input      (din),
        .Enable     (en),
        .Threshold  (thr),
        .SpikeWidth (sw),
        .Output     (dout),
        .SpikeFlag  (flag),
        .dbg_state  (st)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [18:0] exp_q[$];
    string       scen = "reset";

    // ---------------- reference model ----------------
    logic [15:0] m_lfsr;
    state_t      m_mode;
    int          m_left;
    logic        m_pol;

    // ---------------- monitor extras ----------------
    logic        run_chk = 1'b0;
    int          run_len = 0;
    int          gap_len = 0;
    logic        med_on = 1'b0;
    int          med_n = 0;
    int          med_w[5];
    int          srt[5];
    logic [18:0] mon_exp;

    // Hand-computed vector: SEED ACE1 gives lfsr[7:0] = E1, C3, 87, 0F, ...
    // With Threshold 0x10 the 4th cycle starts a positive (b15=0) spike.
    logic signed [15:0] va[10];
    logic [18:0]        ea[10];

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got state=%0d flag=%0b out=%0d, expected state=%0d flag=%0b out=%0d",
                     name, act[18:17], act[16], $signed(act[15:0]),
                     exp[18:17], exp[16], $signed(exp[15:0]));
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_lfsr = SEED;
        m_mode = IDLE;
        m_left = 0;
        m_pol  = 1'b0;
    endtask

    // Predicts what the DUT shows after the coming edge, then advances.
    task automatic model_step(input logic e, input logic [7:0] t, input logic [1:0] w,
                              input logic signed [15:0] d, output logic [18:0] x);
        logic signed [15:0] o;
        logic               f;
        o = d;
        f = 1'b0;
        case (m_mode)
            IDLE: begin
                if (e && (m_lfsr[7:0] < t)) begin
                    m_mode = SPIKE;
                    m_pol  = m_lfsr[15];
                    m_left = int'(w);
                    f      = 1'b1;
                end
            end
            SPIKE: begin
                if (!e) begin
                    m_mode = IDLE;
                end else if (m_left > 0) begin
                    m_left--;
                    f = 1'b1;
                end else begin
                    m_mode = HOLD;
                    m_left = HOLDOFF;
                end
            end
            default: begin
                if (!e) begin
                    m_mode = IDLE;
                end else begin
                    m_left--;
                    if (m_left == 0) m_mode = IDLE;
                end
            end
        endcase
        if (f) o = m_pol ? -16'sd32768 : 16'sd32767;
        x = {m_mode, f, o};
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge: drives inputs, queues the expectation, and
    // returns at the next falling edge.
    task automatic cycle(input logic e, input logic [7:0] t, input logic [1:0] w,
                         input logic signed [15:0] d);
        logic [18:0] x;
        en  = e;
        thr = t;
        sw  = w;
        din = d;
        model_step(e, t, w, d, x);
        exp_q.push_back(x);
        @(negedge clk);
    endtask

    task automatic cycle_hand(input logic e, input logic [7:0] t, input logic [1:0] w,
                              input logic signed [15:0] d, input logic [18:0] hx);
        logic [18:0] x;
        en  = e;
        thr = t;
        sw  = w;
        din = d;
        model_step(e, t, w, d, x);
        exp_q.push_back(hx);
        @(negedge clk);
    endtask

    task automatic run_vector_a();
        for (int i = 0; i < 10; i++) cycle_hand(1'b1, 8'h10, 2'd0, va[i], ea[i]);
    endtask

    // ---------------- monitor ----------------
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            check(scen, {st, flag, dout}, mon_exp);
            if (run_chk) begin
                if (flag) begin
                    if (run_len == 0) begin
                        checks++;
                        if (gap_len < HOLDOFF) begin
                            errors++;
                            $display("FAIL hold_gap: got %0d pass samples, expected at least %0d",
                                     gap_len, HOLDOFF);
                        end
                    end
                    run_len++;
                    gap_len = 0;
                end else begin
                    if (run_len > 0) check_int("spike_len", run_len, 2);
                    run_len = 0;
                    gap_len++;
                end
            end
            if (med_on) begin
                for (int i = 0; i < 4; i++) med_w[i] = med_w[i+1];
                med_w[4] = int'(dout);
                med_n++;
                if (med_n >= 5) begin
                    for (int i = 0; i < 5; i++) srt[i] = med_w[i];
                    for (int i = 0; i < 4; i++)
                        for (int j = 0; j < 4 - i; j++)
                            if (srt[j] > srt[j+1]) begin
                                int tmp;
                                tmp = srt[j];
                                srt[j] = srt[j+1];
                                srt[j+1] = tmp;
                            end
                    check_int("median", srt[2], 1234);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic               found;
        logic signed [15:0] abort_d;
        int                 guard;

        va[0] = 16'sd100;  va[1] = -16'sd1;    va[2] = 16'sh7FFF; va[3] = 16'sd555;
        va[4] = 16'sh8000; va[5] = 16'sd7;     va[6] = -16'sd300; va[7] = 16'sd12;
        va[8] = 16'sd0;    va[9] = 16'sd42;
        ea[0] = {IDLE,  1'b0, 16'd100};
        ea[1] = {IDLE,  1'b0, 16'hFFFF};
        ea[2] = {IDLE,  1'b0, 16'h7FFF};
        ea[3] = {SPIKE, 1'b1, 16'h7FFF};
        ea[4] = {HOLD,  1'b0, 16'h8000};
        ea[5] = {HOLD,  1'b0, 16'd7};
        ea[6] = {HOLD,  1'b0, 16'hFED4};
        ea[7] = {HOLD,  1'b0, 16'd12};
        ea[8] = {IDLE,  1'b0, 16'd0};
        ea[9] = {IDLE,  1'b0, 16'd42};

        rst = 1'b0;
        en  = 1'b0;
        thr = 8'd0;
        sw  = 2'd0;
        din = 16'sd0;
        model_reset();

        // Reset is asynchronous: outputs clear before any clock edge.
        #1 rst = 1'b1;
        #1 check("reset_no_clock", {st, flag, dout}, {IDLE, 1'b0, 16'h0000});
        @(posedge clk);
        #1 check("reset_held", {st, flag, dout}, {IDLE, 1'b0, 16'h0000});
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        scen = "vector_a";
        run_vector_a();

        scen = "threshold_zero";
        for (int i = 0; i < 10000; i++) cycle(1'b1, 8'd0, 2'(i % 4), 16'(100 + i));

        scen = "threshold_max_w2";
        run_len = 0;
        gap_len = 100;
        run_chk = 1'b1;
        for (int i = 0; i < 400; i++) cycle(1'b1, 8'd255, 2'd1, 16'(i * 3 - 500));
        run_chk = 1'b0;

        // Width/threshold change while a spike is in flight.
        scen = "midspike_change";
        for (int i = 0; i < 200; i++) begin
            if (m_mode == SPIKE) cycle(1'b1, 8'd0, 2'd0, 16'(i + 7000));
            else                 cycle(1'b1, 8'd255, 2'd2, 16'(i + 7000));
        end

        scen = "enable_low";
        for (int i = 0; i < 1000; i++) cycle(1'b0, 8'h40, 2'd2, 16'(-i));
        scen = "enable_rise";
        for (int i = 0; i < 300; i++) cycle(1'b1, 8'h40, 2'd2, 16'(i * 11));

        // Drop Enable while the 2nd of 4 spike samples is on Output.
        scen = "abort";
        found   = 1'b0;
        abort_d = 16'sd0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (m_mode == SPIKE && m_left == 2) begin
                abort_d = 16'(-1000 - i);
                cycle(1'b0, 8'd255, 2'd3, abort_d);
                found = 1'b1;
            end else begin
                cycle(1'b1, 8'd255, 2'd3, 16'(2000 + i));
            end
        end
        check_int("abort_reached", int'(found), 1);
        if (found) check("abort_output", {st, flag, dout}, {IDLE, 1'b0, abort_d});
        for (int i = 0; i < 30; i++) cycle(1'b1, 8'd255, 2'd3, 16'(3000 + i));

        // Reset between edges while a spike is on Output.
        scen = "pre_reset";
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cycle(1'b1, 8'd255, 2'd3, 16'(4000 + i));
            if (m_mode == SPIKE) found = 1'b1;
        end
        check_int("spike_before_reset", int'(found), 1);
        check_int("flag_before_reset", int'(flag), 1);
        rst = 1'b1;
        #1 check("async_reset", {st, flag, dout}, {IDLE, 1'b0, 16'h0000});
        @(posedge clk);
        #1 check("async_reset_held", {st, flag, dout}, {IDLE, 1'b0, 16'h0000});
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        scen = "vector_a_again";
        run_vector_a();

        // Spikes fed through a 5-tap median must vanish.
        scen = "median";
        cycle(1'b0, 8'd128, 2'd1, 16'sd1234);
        med_n  = 0;
        med_on = 1'b1;
        for (int i = 0; i < 300; i++) cycle(1'b1, 8'd128, 2'd1, 16'sd1234);
        med_on = 1'b0;

        guard = 0;
        while (exp_q.size() > 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check_int("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
